// File: rtl/tmr_irq_ctrl_pkg.sv
// tmr_irq_ctrl SFR definitions: register layouts, irq source encodings,
// register offsets and the interrupt priority encoder.
package tmr_irq_ctrl_pkg;

   // Source index doubles as irq_id: 0 = m0, 1 = m1, 2 = ovf
   localparam logic [1:0] IRQ_ID_M0  = 2'b00;
   localparam logic [1:0] IRQ_ID_M1  = 2'b01;
   localparam logic [1:0] IRQ_ID_OVF = 2'b10;

   localparam int unsigned OFF_STAT  = 0;
   localparam int unsigned OFF_EN    = 4;
   localparam int unsigned OFF_EVCNT = 8;

   typedef struct packed {
      logic [20:0] rsv1;
      logic [2:0]  orun;
      logic [4:0]  rsv0;
      logic [2:0]  flag;
   } tmr_irq_stat_t;

   typedef struct packed {
      logic        gie;
      logic [27:0] rsv;
      logic [2:0]  src;
   } tmr_irq_en_t;

   typedef struct packed {
      logic [7:0] rsv;
      logic [7:0] ovf;
      logic [7:0] m1;
      logic [7:0] m0;
   } tmr_irq_evcnt_t;

   // pend bit order: [0] m0, [1] m1, [2] ovf; ovf > m0 > m1
   function automatic logic [1:0] irq_pick(input logic [2:0] pend);
      logic [1:0] id;
      id = IRQ_ID_M0;
      priority case (1'b1)
         pend[2]: id = IRQ_ID_OVF;
         pend[0]: id = IRQ_ID_M0;
         pend[1]: id = IRQ_ID_M1;
         default: id = IRQ_ID_M0;
      endcase
      return id;
   endfunction

endpackage

// File: rtl/tmr_irq_ctrl_evt_detect.sv
// tmr_evt_detect: event synchroniser, rising-edge detector and saturating
// 8-bit event counter. Ports: clk, rst_n, clk_en, ev (async level), cnt_clr
// (bus clear), rise (combinational, one cycle per synchronised rise), cnt.
module tmr_evt_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_en,
   input  logic       ev,
   input  logic       cnt_clr,
   output logic       rise,
   output logic [7:0] cnt
);

   logic s_ev;
   logic d_ev;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s_ev = ev;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q <= '0;
            end else if (clk_en) begin
               sync_q[0] <= ev;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign s_ev = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_ev <= 1'b0;
      end else if (clk_en) begin
         d_ev <= s_ev;
      end
   end

   assign rise = s_ev & ~d_ev;

   // A clear that coincides with a rise leaves a count of one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clk_en) begin
         if (cnt_clr) begin
            cnt <= rise ? 8'd1 : 8'd0;
         end else if (rise && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/tmr_irq_ctrl.sv
// tmr_irq_ctrl: sticky event flags, overruns, counters and prioritised irq
// for the timer's match0/match1/ovf events. Ports: sys_* bus and clock,
// three event levels, irq_ack in; sfr_rd_dout (0 when unaddressed),
// irq_req and irq_id out.
module tmr_irq_ctrl
   import tmr_irq_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  sys_clk_en,
   input  logic [ADDR_WIDTH-1:0] sys_addr,
   input  logic                  sys_wr_en,
   input  logic [DATA_WIDTH-1:0] sys_sw_value,
   input  logic                  match0_event,
   input  logic                  match1_event,
   input  logic                  ovf_event,
   input  logic                  irq_ack,
   output logic [DATA_WIDTH-1:0] sfr_rd_dout,
   output logic                  irq_req,
   output logic [1:0]            irq_id
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_STAT =
      BASE_ADDR + ADDR_WIDTH'(OFF_STAT);
   localparam logic [ADDR_WIDTH-1:0] ADDR_EN =
      BASE_ADDR + ADDR_WIDTH'(OFF_EN);
   localparam logic [ADDR_WIDTH-1:0] ADDR_EVCNT =
      BASE_ADDR + ADDR_WIDTH'(OFF_EVCNT);

   logic [31:0] wd;
   logic        unused_wd;
   logic        sel_stat;
   logic        sel_en;
   logic        sel_evcnt;
   logic        wr_stat;
   logic        wr_en_reg;
   logic        wr_evcnt;

   logic [2:0]  evt;
   logic [2:0]  rise;
   logic [7:0]  cnt [3];

   logic [2:0]  flag_q;
   logic [2:0]  orun_q;
   logic [2:0]  en_src_q;
   logic        gie_q;

   logic        ack_ok;
   logic [2:0]  ack_clr;
   logic [2:0]  w1c_flag;
   logic [2:0]  w1c_orun;
   logic [2:0]  clr;
   logic [2:0]  pend;

   tmr_irq_stat_t  stat_rd;
   tmr_irq_en_t    en_rd;
   tmr_irq_evcnt_t evcnt_rd;
   logic [31:0]    rd;

   assign wd        = 32'(sys_sw_value);
   assign unused_wd = ^{wd[30:11], wd[7:3]};

   assign sel_stat  = (sys_addr == ADDR_STAT);
   assign sel_en    = (sys_addr == ADDR_EN);
   assign sel_evcnt = (sys_addr == ADDR_EVCNT);

   assign wr_stat   = sys_wr_en & sel_stat;
   assign wr_en_reg = sys_wr_en & sel_en;
   assign wr_evcnt  = sys_wr_en & sel_evcnt;

   assign evt = {ovf_event, match1_event, match0_event};

   for (genvar g = 0; g < 3; g++) begin : g_evt
      tmr_evt_detect #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_evt (
         .clk     (sys_clk),
         .rst_n   (sys_rst_n),
         .clk_en  (sys_clk_en),
         .ev      (evt[g]),
         .cnt_clr (wr_evcnt),
         .rise    (rise[g]),
         .cnt     (cnt[g])
      );
   end

   // An ack only counts while a request is actually presented
   assign ack_ok     = irq_ack & irq_req;
   assign ack_clr[0] = ack_ok & (irq_id == IRQ_ID_M0);
   assign ack_clr[1] = ack_ok & (irq_id == IRQ_ID_M1);
   assign ack_clr[2] = ack_ok & (irq_id == IRQ_ID_OVF);

   assign w1c_flag = wr_stat ? wd[2:0]  : 3'b000;
   assign w1c_orun = wr_stat ? wd[10:8] : 3'b000;
   assign clr      = w1c_flag | ack_clr;

   // Set beats clear; a new overrun beats its own W1C
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         flag_q <= '0;
         orun_q <= '0;
      end else if (sys_clk_en) begin
         flag_q <= rise | (flag_q & ~clr);
         orun_q <= (rise & flag_q & ~clr) | (orun_q & ~w1c_orun);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         en_src_q <= '0;
         gie_q    <= 1'b0;
      end else if (sys_clk_en && wr_en_reg) begin
         en_src_q <= wd[2:0];
         gie_q    <= wd[31];
      end
   end

   assign pend = flag_q & en_src_q & {3{gie_q}};

   // irq_id is left alone while idle so it holds the last source
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         irq_req <= 1'b0;
         irq_id  <= IRQ_ID_M0;
      end else if (sys_clk_en) begin
         if (|pend) begin
            irq_req <= 1'b1;
            irq_id  <= irq_pick(pend);
         end else begin
            irq_req <= 1'b0;
         end
      end
   end

   always_comb begin
      stat_rd      = '0;
      stat_rd.flag = flag_q;
      stat_rd.orun = orun_q;
      en_rd        = '0;
      en_rd.gie    = gie_q;
      en_rd.src    = en_src_q;
      evcnt_rd     = '0;
      evcnt_rd.m0  = cnt[0];
      evcnt_rd.m1  = cnt[1];
      evcnt_rd.ovf = cnt[2];
      rd           = '0;
      unique case (1'b1)
         sel_stat:  rd = stat_rd;
         sel_en:    rd = en_rd;
         sel_evcnt: rd = evcnt_rd;
         default:   rd = '0;
      endcase
   end

   assign sfr_rd_dout = DATA_WIDTH'(rd);

endmodule

// File: tb/tb_tmr_irq_ctrl.sv
// tb_tmr_irq_ctrl: directed plan plus randomized traffic against a
// sample-history reference model of tmr_irq_ctrl.
module tb_tmr_irq_ctrl;

   localparam int SS = 2;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        clk_en = 1'b0;
   logic [31:0] addr   = '0;
   logic        wr_en  = 1'b0;
   logic [31:0] wdat   = '0;
   logic        m0     = 1'b0;
   logic        m1     = 1'b0;
   logic        ovf    = 1'b0;
   logic        ack    = 1'b0;
   logic [31:0] rdata;
   logic        irq_req;
   logic [1:0]  irq_id;

   int n_run  = 0;
   int n_fail = 0;

   tmr_irq_ctrl #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .BASE_ADDR   (32'h0),
      .SYNC_STAGES (SS)
   ) dut (
      .sys_clk      (clk),
      .sys_rst_n    (rst_n),
      .sys_clk_en   (clk_en),
      .sys_addr     (addr),
      .sys_wr_en    (wr_en),
      .sys_sw_value (wdat),
      .match0_event (m0),
      .match1_event (m1),
      .ovf_event    (ovf),
      .irq_ack      (ack),
      .sfr_rd_dout  (rdata),
      .irq_req      (irq_req),
      .irq_id       (irq_id)
   );

   always #5 clk = ~clk;

   // Reference model: hist[s][j] is the event level seen j enabled
   // edges ago (j = 0 is the current edge); pre-reset history is low.
   int hist [3][5];
   int mf [3];
   int mo [3];
   int mc [3];
   int men [3];
   int mgie;
   int mreq;
   int mid;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 3; s++) begin
         for (int j = 0; j < 5; j++) hist[s][j] = 0;
         mf[s] = 0; mo[s] = 0; mc[s] = 0; men[s] = 0;
      end
      mgie = 0; mreq = 0; mid = 0;
   endtask

   function automatic logic [31:0] mread(input logic [31:0] a);
      logic [31:0] v;
      v = '0;
      if (a == 32'd0) begin
         for (int s = 0; s < 3; s++)
            v = v + 32'(mf[s] << s) + 32'(mo[s] << (8 + s));
      end else if (a == 32'd4) begin
         for (int s = 0; s < 3; s++) v = v + 32'(men[s] << s);
         if (mgie != 0) v[31] = 1'b1;
      end else if (a == 32'd8) begin
         v = 32'(mc[0] + mc[1] * 256 + mc[2] * 65536);
      end
      return v;
   endfunction

   task automatic model_edge();
      int ev [3];
      int rs [3];
      int nreq, nid, ackv, clrf, clro;
      int order [3];
      if (!clk_en) return;
      ev[0] = int'(m0); ev[1] = int'(m1); ev[2] = int'(ovf);
      for (int s = 0; s < 3; s++) begin
         for (int j = 4; j > 0; j--) hist[s][j] = hist[s][j-1];
         hist[s][0] = ev[s];
         rs[s] = (hist[s][SS] != 0 && hist[s][SS+1] == 0) ? 1 : 0;
      end
      // Request follows the flags/enables held before this edge
      order[0] = 2; order[1] = 0; order[2] = 1;
      nreq = 0; nid = mid;
      for (int k = 0; k < 3; k++) begin
         if (nreq == 0 && mf[order[k]] != 0 && men[order[k]] != 0 &&
             mgie != 0) begin
            nreq = 1; nid = order[k];
         end
      end
      ackv = (ack && mreq != 0) ? 1 : 0;
      for (int s = 0; s < 3; s++) begin
         clrf = ((wr_en && addr == 0 && wdat[s]) ||
                 (ackv != 0 && mid == s)) ? 1 : 0;
         clro = (wr_en && addr == 0 && wdat[8+s]) ? 1 : 0;
         mo[s] = ((rs[s] != 0 && mf[s] != 0 && clrf == 0) ||
                  (mo[s] != 0 && clro == 0)) ? 1 : 0;
         mf[s] = (rs[s] != 0 || (mf[s] != 0 && clrf == 0)) ? 1 : 0;
         if (wr_en && addr == 8) mc[s] = rs[s];
         else if (rs[s] != 0 && mc[s] < 255) mc[s] = mc[s] + 1;
      end
      if (wr_en && addr == 4) begin
         for (int s = 0; s < 3; s++) men[s] = int'(wdat[s]);
         mgie = int'(wdat[31]);
      end
      mreq = nreq; mid = nid;
   endtask

   // Check read data before the edge (pre-write value), then clock,
   // then check the registered irq outputs.
   task automatic tick();
      #1;
      chk("rd_pre", rdata, mread(addr));
      @(posedge clk);
      model_edge();
      #1;
      chk("irq_req", 32'(irq_req), 32'(mreq));
      chk("irq_id", 32'(irq_id), 32'(mid));
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdat = d; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a,
                         input logic [31:0] exp);
      addr = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #12;
      chk("rst_req", 32'(irq_req), 32'd0);
      chk("rst_id", 32'(irq_id), 32'd0);
      rd_chk("rst_stat", 32'd0, 32'd0);
      rd_chk("rst_en", 32'd4, 32'd0);
      rd_chk("rst_evcnt", 32'd8, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; clk_en = 1'b1;

      // Basic event
      wr(32'd4, 32'h8000_0001);
      m0 = 1'b1;
      tick();
      tick();
      rd_chk("b_stat_e2", 32'd0, 32'd0);
      tick();
      rd_chk("b_m0if_e3", 32'd0, 32'd1);
      chk("b_req_e3", 32'(irq_req), 32'd0);
      tick();
      chk("b_req_e4", 32'(irq_req), 32'd1);
      chk("b_id_e4", 32'(irq_id), 32'd0);
      repeat (6) tick();
      m0 = 1'b0;
      rd_chk("b_evcnt", 32'd8, 32'd1);
      ack = 1'b1; tick(); ack = 1'b0;
      tick(); tick();
      chk("b_req_off", 32'(irq_req), 32'd0);

      // Priority
      wr(32'd4, 32'h8000_0007);
      m0 = 1'b1; m1 = 1'b1; ovf = 1'b1;
      tick();
      m0 = 1'b0; m1 = 1'b0; ovf = 1'b0;
      repeat (3) tick();
      chk("p_req", 32'(irq_req), 32'd1);
      chk("p_id_ovf", 32'(irq_id), 32'd2);
      ack = 1'b1; tick(); ack = 1'b0; tick();
      chk("p_id_m0", 32'(irq_id), 32'd0);
      ack = 1'b1; tick(); ack = 1'b0; tick();
      chk("p_id_m1", 32'(irq_id), 32'd1);
      ack = 1'b1; tick(); ack = 1'b0; tick();
      chk("p_req_off", 32'(irq_req), 32'd0);
      rd_chk("p_stat", 32'd0, 32'd0);

      // Overrun
      m1 = 1'b1; tick(); m1 = 1'b0;
      repeat (4) tick();
      m1 = 1'b1; tick(); m1 = 1'b0;
      repeat (4) tick();
      rd_chk("o_stat", 32'd0, 32'h0000_0202);
      wr(32'd0, 32'h0000_0202);
      rd_chk("o_stat_clr", 32'd0, 32'd0);

      // Set/clear collision on ovf
      ovf = 1'b1; tick(); ovf = 1'b0;
      repeat (4) tick();
      ovf = 1'b1; tick(); ovf = 1'b0;
      tick();
      wr(32'd0, 32'h0000_0004);
      rd_chk("c_stat", 32'd0, 32'h0000_0004);
      wr(32'd4, 32'd0);
      tick();
      chk("c_req_off", 32'(irq_req), 32'd0);
      ack = 1'b1; tick(); ack = 1'b0;
      rd_chk("c_ack_ign", 32'd0, 32'h0000_0004);
      wr(32'd0, 32'h0000_0707);

      // Saturation and clear
      wr(32'd8, 32'd0);
      for (int i = 0; i < 300; i++) begin
         m0 = 1'b1; tick();
         m0 = 1'b0; tick();
      end
      repeat (4) tick();
      rd_chk("s_sat", 32'd8, 32'd255);
      wr(32'd8, $urandom);
      rd_chk("s_clr", 32'd8, 32'd0);

      // Gating and reset
      wr(32'd0, 32'h0000_0707);
      wr(32'd4, 32'h8000_0007);
      m1 = 1'b1; tick(); m1 = 1'b0;
      repeat (4) tick();
      clk_en = 1'b0; ovf = 1'b1;
      repeat (5) tick();
      rd_chk("g_stat", 32'd0, 32'h0000_0002);
      rd_chk("g_evcnt", 32'd8, 32'h0000_0100);
      chk("g_req", 32'(irq_req), 32'd1);
      chk("g_id", 32'(irq_id), 32'd1);
      clk_en = 1'b1;
      tick(); tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("r_req", 32'(irq_req), 32'd0);
      chk("r_id", 32'(irq_id), 32'd0);
      rd_chk("r_stat", 32'd0, 32'd0);
      rd_chk("r_en", 32'd4, 32'd0);
      rd_chk("r_evcnt", 32'd8, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) tick();
      rd_chk("r_rise_stat", 32'd0, 32'h0000_0004);
      rd_chk("r_rise_evc", 32'd8, 32'h0001_0000);
      ovf = 1'b0;

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         clk_en = ($urandom_range(7) != 0);
         if ($urandom_range(3) == 0) m0 = ~m0;
         if ($urandom_range(3) == 0) m1 = ~m1;
         if ($urandom_range(3) == 0) ovf = ~ovf;
         ack = ($urandom_range(3) == 0);
         case ($urandom_range(4))
            0: addr = 32'd0;
            1: addr = 32'd4;
            2: addr = 32'd8;
            3: addr = 32'd12;
            default: addr = $urandom;
         endcase
         wr_en = ($urandom_range(5) == 0);
         wdat = $urandom;
         tick();
      end
      wr_en = 1'b0; ack = 1'b0;
      m0 = 1'b0; m1 = 1'b0; ovf = 1'b0;
      clk_en = 1'b1;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/tmr_irq_ctrl.md
Name: tmr_irq_ctrl

Overview:
- Downstream consumer of the 32-bit timer's match0_event, match1_event and ovf_event outputs.
- Synchronises each event and edge-detects it into a sticky flag, with overrun tracking and saturating event counters.
- Generates a prioritised interrupt request with an ack handshake toward the core.
- Exposes STAT, EN and EVCNT SFRs on the shared system bus; read data is zero when not addressed, so it is wired-OR compatible.

Parameters:
- DATA_WIDTH, 32, bus data width.
- ADDR_WIDTH, 32, bus address width.
- BASE_ADDR, 0, address of STAT; EN at +4; EVCNT at +8.
- SYNC_STAGES, 2, flop stages on each event input; legal range 0..3.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- sys_clk_en  in  1  global enable; all state holds when 0.
- sys_addr  in  ADDR_WIDTH  bus address.
- sys_wr_en  in  1  bus write strobe.
- sys_sw_value  in  DATA_WIDTH  bus write data.
- match0_event  in  1  timer match0 event; level, may last many sys_clk cycles.
- match1_event  in  1  timer match1 event.
- ovf_event  in  1  timer overflow event.
- irq_ack  in  1  one-cycle pulse; acknowledges the irq_id currently presented.
- sfr_rd_dout  out  DATA_WIDTH  read data; 0 when no register is addressed.
- irq_req  out  1  registered interrupt request.
- irq_id  out  2  registered source: 00 = m0, 01 = m1, 10 = ovf.

Behaviour:
- Reset state: every register and output is 0 (flags, overruns, EN, EVCNT, sync flops, edge flops, irq_req, irq_id).
- Clock enable: all register updates, including the sync chain and bus writes, occur only on edges where sys_clk_en = 1.
- Event detection:
  - Each event passes through SYNC_STAGES flops to give s_ev; a delayed copy d_ev is kept.
  - rise = s_ev & ~d_ev.
  - The flag sets on the edge that registers rise, i.e. the (SYNC_STAGES+1)th enabled edge that samples the event high.
  - An event held high produces exactly one rise. It must return low for at least one synchronised cycle before it can retrigger.
- STAT (BASE+0):
  - Bit 0 M0IF, bit 1 M1IF, bit 2 OVFIF.
  - Bits 8..10: overrun flags OR0/OR1/ORV.
  - All bits are write-1-to-clear; other bits read 0.
- EN (BASE+4): bits 0..2 are per-source enables, bit 31 is GIE; read/write; other bits read 0.
- EVCNT (BASE+8):
  - [7:0] m0 count, [15:8] m1 count, [23:16] ovf count.
  - Each count is 8-bit, increments on rise and saturates at 255.
  - Any write clears all three counts, regardless of write data.
  - If a write and a rise occur in the same cycle, the count becomes 1.
- Flag next-state, per source:
  - A flag clears on a W1C bit, or on irq_ack when irq_id selects that source.
  - If rise occurs in the same cycle, set wins and the flag ends at 1.
  - The overrun bit sets when rise occurs while the flag is 1 and is not being cleared that cycle. It clears only by W1C.
  - The overrun W1C loses to a simultaneous new overrun.
- Interrupt output:
  - pend = flags & EN[2:0] & {3{GIE}}.
  - Priority is ovf > m0 > m1.
  - irq_req and irq_id are registered from pend: they assert one edge after the flag sets.
  - irq_id holds its last value when irq_req = 0.
- Ack handshake:
  - irq_ack is honoured only while irq_req = 1; otherwise it is ignored.
  - An acked source's flag clears at that edge. irq_req then deasserts on the following edge, unless another source is pending, in which case irq_id switches to it.
- Reads:
  - Combinational on sys_addr; the full address is compared.
  - Writes to other addresses are ignored.
  - A read in the same cycle as a write returns the pre-write value.
- Reset mid-operation: asynchronous clear of all state; events already in the sync chain are lost.
  - After reset is released, an event input that is still high is seen as a rise, because d_ev is 0.

Decomposition:
- The shared SFR-definitions package holds:
  - struct typedefs tmr_irq_stat_t, tmr_irq_en_t and tmr_irq_evcnt_t;
  - the IRQ_ID_M0, IRQ_ID_M1 and IRQ_ID_OVF encodings;
  - the register offsets.
- One sub-module, tmr_evt_detect: synchroniser, rise detector and saturating 8-bit counter. It is instantiated three times.

Test Plan:
- Basic event (SYNC_STAGES = 2): write EN = 0x8000_0001, then hold match0_event high for 10 cycles. Required response:
  - M0IF sets on the 3rd edge;
  - irq_req = 1 and irq_id = 00 one edge later;
  - EVCNT[7:0] = 1 (single rise).
- Priority: pulse all three events in the same cycle with EN = 0x8000_0007. Required response:
  - irq_id = 10;
  - after irq_ack, irq_id = 00; after a second ack, irq_id = 01; after a third ack, irq_req = 0;
  - STAT = 0.
- Overrun: leave M1IF set and unacked, then send a second match1 rise. Required response:
  - STAT = 0x0000_0202.
  - Writing 0x0000_0202 to STAT gives STAT = 0.
- Set/clear collision: a W1C of bit 2 coincides with an ovf rise. Required response: OVFIF = 1 and ORV = 0. Also check that irq_ack with irq_req = 0 leaves the flags unchanged.
- Saturation and clear: send 300 match0 rises. Required response:
  - EVCNT[7:0] = 255;
  - after a write to EVCNT, the read returns 0.
- Gating and reset: hold sys_clk_en = 0 while an event pulses, then assert sys_rst_n low mid-pulse. Required response:
  - no state changes while sys_clk_en = 0;
  - on reset, all outputs are 0 and sfr_rd_dout = 0 for all three addresses.
